fib_bin2bcd: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) directly downstream of the `fibonacci` core. It consumes the 20-bit result `f` on that core's `done_tick`. It produces packed BCD digits plus a significant-digit count for the display/readout stage. It uses the same `start`/`ready`/`done_tick` handshake as the core, so the two chain by wiring `done_tick` to `start` and `f` to `bin`.

---
 rtl/fib_bcd_pkg.sv | 33 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/fib_bin2bcd.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fib_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package fib_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BIN_W_DEF  = 20;
    localparam int DIGITS_DEF = 7;
    localparam int BCD_W      = 4;

    // True when DIGITS decimal digits can hold every BIN_W-bit value,
    // i.e. 10^digits > 2^bin_w. Evaluated at elaboration time only.
    function automatic bit bcd_fits(input int bin_w, input int digits);
        longint unsigned p10;
        longint unsigned p2;
        if (digits >= 19) begin
            return (bin_w < 63);
        end
        if (bin_w >= 63) begin
            return 1'b0;
        end
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        p2 = 64'd1 << bin_w;
        return (p10 > p2);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: +3 when the digit is 5 or more.
module bcd_digit_adj
    import fib_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Per-digit correction; no carry leaves the digit because din <= 9.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// start/ready/done_tick handshake matching the upstream fibonacci core.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready=1, waits for start, then loads sh/acc/n
//   OP    | one add-3 + shift per cycle, BIN_W cycles total
//   DONE  | done_tick=1 for one cycle; bcd/nd latch on the exit edge
module fib_bin2bcd
    import fib_bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin,
    output logic                         ready,
    output logic                         done_tick,
    output logic [BCD_W*DIGITS-1:0]      bcd,
    output logic [$clog2(DIGITS+1)-1:0]  nd
);

    localparam int ACC_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ND_W  = $clog2(DIGITS + 1);

    if (!bcd_fits(BIN_W, DIGITS)) begin : g_digits_too_few
        $error("fib_bin2bcd: DIGITS too small to hold a BIN_W-bit value");
    end

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  sh_q,    sh_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  n_q,     n_d;
    logic [ACC_W-1:0]  bcd_q,   bcd_d;
    logic [ND_W-1:0]   nd_q,    nd_d;

    logic [ACC_W-1:0]  acc_adj;
    logic [ND_W-1:0]   nd_calc;

    // Add-3 correction applied to every digit of the accumulator in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[BCD_W*g +: BCD_W]),
            .dout (acc_adj[BCD_W*g +: BCD_W])
        );
    end

    // Significant-digit count of the finished accumulator; zero reports one digit.
    always_comb begin
        nd_calc = ND_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[BCD_W*i +: BCD_W] != '0) begin
                nd_calc = ND_W'(i + 1);
            end
        end
    end

    // Next-state and datapath control for the three-state conversion FSM.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        n_d     = n_q;
        bcd_d   = bcd_q;
        nd_d    = nd_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    acc_d   = '0;
                    n_d     = CNT_W'(BIN_W);
                    state_d = OP;
                end
            end
            OP: begin
                // Full-width shift drops the adjusted MSB, which is always zero
                // because the digit count covers the whole input range.
                acc_d = (acc_adj << 1) | {{(ACC_W-1){1'b0}}, sh_q[BIN_W-1]};
                sh_d  = sh_q << 1;
                n_d   = n_q - CNT_W'(1);
                if (n_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                nd_d    = nd_calc;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            bcd_q   <= '0;
            nd_q    <= ND_W'(1);
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            bcd_q   <= bcd_d;
            nd_q    <= nd_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign bcd       = bcd_q;
    assign nd        = nd_q;

endmodule
